// File: rtl/diff_serial_if.sv
// diff_serial request/result bundle.
// master drives the request side; slave is the difference unit.
interface diff_serial_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             borrow;
    logic             overflow;
    logic             zero;

    modport master (
        output start,
        output mode,
        output in_a,
        output in_b,
        input  busy,
        input  done,
        input  result,
        input  borrow,
        input  overflow,
        input  zero
    );

    modport slave (
        input  start,
        input  mode,
        input  in_a,
        input  in_b,
        output busy,
        output done,
        output result,
        output borrow,
        output overflow,
        output zero
    );
endinterface

// File: rtl/diff_serial.sv
// diff_serial: digit-serial a-b with wrap, absolute and saturating modes.
// One DIGIT slice per cycle; |a-b| uses a second serial negate pass.
module diff_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    diff_serial_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        NEG,
        FIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_mode;
    logic [CW-1:0]    r_cnt;
    logic             r_bin;
    logic             r_sa;
    logic             r_sb;
    logic             r_raw_b;
    logic             r_raw_v;
    logic             r_done;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_zero;

    logic [DIGIT-1:0] w_x;
    logic [DIGIT-1:0] w_y;
    logic [DIGIT-1:0] w_d;
    logic [DIGIT:0]   w_sub;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_fix;

    // Shared slice: SUB computes a-b, NEG computes 0-diff.
    always_comb begin
        w_x = r_a[DIGIT-1:0];
        w_y = r_b[DIGIT-1:0];
        if (r_state == NEG) begin
            w_x = '0;
            w_y = r_diff[DIGIT-1:0];
        end
    end

    assign w_sub   = {1'b0, w_x} - {1'b0, w_y} - {{DIGIT{1'b0}}, r_bin};
    assign w_d     = w_sub[DIGIT-1:0];
    assign w_bout  = w_sub[DIGIT];
    assign w_last  = (r_cnt == LAST);
    assign w_shift = WIDTH'({w_d, r_diff} >> DIGIT);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = SUB;
                end
            end
            SUB: begin
                if (w_last) begin
                    if (r_mode == 2'd1 && w_bout) begin
                        w_next = NEG;
                    end else begin
                        w_next = FIN;
                    end
                end
            end
            NEG: begin
                if (w_last) begin
                    w_next = FIN;
                end
            end
            FIN: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_fix = r_diff;
        unique case (r_mode)
            2'd2: begin
                if (r_raw_v) begin
                    w_fix = r_sa ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
            2'd3: begin
                if (r_raw_b) begin
                    w_fix = '0;
                end
            end
            default: begin
                w_fix = r_diff;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_mode   <= '0;
            r_cnt    <= '0;
            r_bin    <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_raw_b  <= 1'b0;
            r_raw_v  <= 1'b0;
            r_result <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == FIN);
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a    <= bus.in_a;
                        r_b    <= bus.in_b;
                        r_mode <= bus.mode;
                        r_sa   <= bus.in_a[WIDTH-1];
                        r_sb   <= bus.in_b[WIDTH-1];
                        r_diff <= '0;
                        r_cnt  <= '0;
                        r_bin  <= 1'b0;
                    end
                end
                SUB: begin
                    r_a    <= r_a >> DIGIT;
                    r_b    <= r_b >> DIGIT;
                    r_diff <= w_shift;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_bin   <= 1'b0;
                        r_raw_b <= w_bout;
                        r_raw_v <= (r_sa != r_sb) && (w_d[DIGIT-1] != r_sa);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        r_bin <= w_bout;
                    end
                end
                NEG: begin
                    r_diff <= w_shift;
                    if (w_last) begin
                        r_cnt <= '0;
                        r_bin <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        r_bin <= w_bout;
                    end
                end
                FIN: begin
                    r_result <= w_fix;
                    r_borrow <= r_raw_b;
                    r_ovf    <= r_raw_v;
                    r_zero   <= (w_fix == '0);
                end
            endcase
        end
    end

    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.borrow   = r_borrow;
    assign bus.overflow = r_ovf;
    assign bus.zero     = r_zero;
endmodule

// File: tb/tb_diff_serial.sv
// tb_diff_serial: random and directed stimulus for diff_serial.
// Outputs are compared every cycle against an arithmetic reference model.
module tb_diff_serial;
    localparam int W = 32;
    localparam int N = 4;

    typedef struct packed {
        logic [31:0] res;
        logic        b;
        logic        v;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    diff_serial_if #(.WIDTH(W)) bus ();
    diff_serial_if #(.WIDTH(W)) bus32 ();
    diff_serial_if #(.WIDTH(W)) bus1 ();

    diff_serial #(.WIDTH(W), .DIGIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    diff_serial #(.WIDTH(W), .DIGIT(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32)
    );
    diff_serial #(.WIDTH(W), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_done = 0;
    bit   m_pend = 0;
    int   m_acc = 0;
    int   m_done_edge = 0;
    int   m_free = 0;
    exp_t m_exp = '0;
    exp_t m_held = '0;

    function automatic exp_t model(input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [1:0] m);
        exp_t e;
        logic [31:0] raw;
        raw = a - b;
        e.b = (a < b);
        e.v = (a[31] != b[31]) && (raw[31] != a[31]);
        case (m)
            2'd0: e.res = raw;
            2'd1: e.res = e.b ? (b - a) : raw;
            2'd2: e.res = e.v ? (a[31] ? 32'h8000_0000 : 32'h7fff_ffff) : raw;
            default: e.res = e.b ? 32'd0 : raw;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    function automatic int lat(input logic [31:0] a,
                               input logic [31:0] b,
                               input logic [1:0] m);
        return (m == 2'd1 && a < b) ? 2 * N + 1 : N + 1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h",
                     nm, cyc, got, exp);
        end
    endtask

    // Acceptance is decided by the model: an IDLE unit takes start.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && bus.start && cyc >= m_free) begin
            m_exp       = model(bus.in_a, bus.in_b, bus.mode);
            m_acc       = cyc;
            m_done_edge = cyc + lat(bus.in_a, bus.in_b, bus.mode);
            m_free      = m_done_edge + 1;
            m_pend      = 1;
        end
    end

    always @(negedge rst_n) begin
        m_pend = 0;
        m_held = '0;
        m_free = 0;
    end

    always @(negedge clk) begin
        bit ed;
        ed = m_pend && (cyc == m_done_edge);
        if (ed) begin
            m_held = m_exp;
            m_pend = 0;
            n_done++;
        end
        chk("cycle", 64'({bus.done, bus.busy, bus.result,
                          bus.borrow, bus.overflow, bus.zero}),
                     64'({ed, m_pend, m_held}));
    end

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (bus.done) seen = 1;
            else @(negedge clk);
        end
    endtask

    task automatic run_op(input string nm,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] m, input logic [31:0] xr,
                          input logic xb, input logic xv, input logic xz,
                          input int xlat);
        bit seen;
        bus.in_a  = a;
        bus.in_b  = b;
        bus.mode  = m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(seen);
        chk({nm, "_done"}, 64'(seen), 64'd1);
        if (seen) begin
            chk(nm, 64'({bus.result, bus.borrow, bus.overflow, bus.zero}),
                    64'({xr, xb, xv, xz}));
            chk({nm, "_lat"}, 64'(cyc - m_acc), 64'(xlat));
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'h7fff_ffff;
            2: return 32'h8000_0000;
            3: return 32'hffff_ffff;
            4: return 32'($urandom % 100);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit seen;
        int d1;
        int e0;
        int l32;
        int l1;
        int nd;
        logic [31:0] r32;
        logic [31:0] r1;

        bus.start = 0;   bus.mode = 0;   bus.in_a = 0;   bus.in_b = 0;
        bus32.start = 0; bus32.mode = 0; bus32.in_a = 0; bus32.in_b = 0;
        bus1.start = 0;  bus1.mode = 0;  bus1.in_a = 0;  bus1.in_b = 0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", 64'({bus.busy, bus.done, bus.result,
                          bus.borrow, bus.overflow, bus.zero}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("wrap",     32'd78, 32'd34, 2'd0, 32'd44, 0, 0, 0, 5);
        run_op("wrap_neg", 32'd12, 32'd34, 2'd0, 32'hffff_ffea, 1, 0, 0, 5);
        run_op("abs_neg",  32'd12, 32'd34, 2'd1, 32'd22, 1, 0, 0, 9);
        run_op("abs_pos",  32'd90, 32'd45, 2'd1, 32'd45, 0, 0, 0, 5);
        run_op("ssat_hi",  32'h7fff_ffff, 32'hffff_ffff, 2'd2,
               32'h7fff_ffff, 1, 1, 0, 5);
        run_op("ssat_lo",  32'h8000_0000, 32'd1, 2'd2,
               32'h8000_0000, 0, 1, 0, 5);
        run_op("ssat_ok",  32'd16, 32'd68, 2'd2, 32'hffff_ffcc, 1, 0, 0, 5);
        run_op("usat",     32'd16, 32'd68, 2'd3, 32'd0, 1, 0, 1, 5);
        run_op("zero",     32'd45, 32'd45, 2'd0, 32'd0, 0, 0, 1, 5);

        // A start pulse two cycles into an operation must be ignored.
        bus.in_a = 32'd78; bus.in_b = 32'd34; bus.mode = 2'd0; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        @(negedge clk);
        bus.in_a = 32'd1; bus.in_b = 32'd2; bus.mode = 2'd1; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        wait_done(seen);
        chk("ignore_done", 64'(seen), 64'd1);
        chk("ignore_res", 64'(bus.result), 64'd44);
        @(negedge clk);

        // start held through done: second op follows after N+2 cycles.
        bus.in_a = 32'd100; bus.in_b = 32'd1; bus.mode = 2'd0; bus.start = 1;
        @(negedge clk);
        wait_done(seen);
        chk("b2b_first", 64'({seen, bus.result}), 64'({1'b1, 32'd99}));
        d1 = cyc;
        bus.in_a = 32'd200; bus.in_b = 32'd50;
        @(negedge clk);
        bus.start = 0;
        wait_done(seen);
        chk("b2b_second", 64'({seen, bus.result}), 64'({1'b1, 32'd150}));
        chk("b2b_gap", 64'(cyc - d1), 64'(N + 2));
        @(negedge clk);

        // Reset at E3 of an absolute-value operation.
        bus.in_a = 32'd12; bus.in_b = 32'd34; bus.mode = 2'd1; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", 64'({bus.busy, bus.done, bus.result,
                              bus.borrow, bus.overflow, bus.zero}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("rst_nodone", 64'(nd), 64'd0);
        run_op("after_rst", 32'd98, 32'd34, 2'd0, 32'd64, 0, 0, 0, 5);

        // DIGIT=32 and DIGIT=1 instances, scenario 1.
        bus32.in_a = 32'd78; bus32.in_b = 32'd34; bus32.start = 1;
        bus1.in_a  = 32'd78; bus1.in_b  = 32'd34; bus1.start  = 1;
        @(negedge clk);
        bus32.start = 0;
        bus1.start  = 0;
        e0 = cyc;
        l32 = -1; l1 = -1; r32 = '0; r1 = '0;
        for (int k = 0; k < 60 && (l32 < 0 || l1 < 0); k++) begin
            if (bus32.done && l32 < 0) begin
                l32 = cyc - e0;
                r32 = bus32.result;
            end
            if (bus1.done && l1 < 0) begin
                l1 = cyc - e0;
                r1 = bus1.result;
            end
            @(negedge clk);
        end
        chk("d32_lat", 64'(l32), 64'd2);
        chk("d32_res", 64'(r32), 64'd44);
        chk("d1_lat", 64'(l1), 64'd33);
        chk("d1_res", 64'(r1), 64'd44);

        // Random traffic; start and operands also toggle while busy.
        nd = n_done;
        repeat (3000) begin
            @(negedge clk);
            bus.start = ($urandom % 3 == 0);
            bus.in_a  = pick();
            bus.in_b  = ($urandom % 8 == 0) ? bus.in_a : pick();
            bus.mode  = 2'($urandom % 4);
        end
        @(negedge clk);
        bus.start = 0;
        repeat (20) @(negedge clk);
        chk("rand_ops", 64'(n_done - nd > 100), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
